fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline: owns the program counter, drives the instruction-memory read address, and registers the fetched word into the IF/ID pipeline register consumed by the decode stage and its control decoder. It honours stall requests from the hazard unit, control-flow redirects from execute, and a halt request from decode. Every output is registered except the memory address.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- i_clk  input  1  core clock; all state updates on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_imem_raddr  output  32  instruction-memory read address; equals the PC register.
- i_imem_rdata  input  32  instruction word for o_imem_raddr, combinational, valid in the same cycle.
- i_stall  input  1  hold the PC and IF/ID contents.
- i_redirect  input  1  taken branch or jump resolved in execute.
- i_redirect_pc  input  32  target PC for i_redirect.
- i_halt  input  1  decode has seen ECALL/EBREAK; stop fetching.
- o_if_id_inst  output  32  registered instruction for decode.
- o_if_id_pc  output  32  PC of o_if_id_inst.
- o_if_id_pc4  output  32  o_if_id_pc + 4, modulo 2^32.
- o_if_id_valid  output  1  o_if_id_inst is a real instruction, not a bubble.
- o_halted  output  1  fetch state machine is in HALT.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values:
  - PC = RESET_ADDR.
  - o_if_id_inst = NOP (32'h0000_0013).
  - o_if_id_pc = 0, o_if_id_pc4 = 4.
  - o_if_id_valid = 0, o_halted = 0.
- Per-cycle priority in RUN: reset > redirect > halt > stall > advance.
  - **redirect:** PC <= i_redirect_pc. IF/ID is flushed: inst = NOP, valid = 0, pc/pc4 unchanged. This applies even if i_stall is high. Any i_halt in the same cycle is ignored, because it came from a wrong-path instruction.
  - **halt:** go to HALT. PC is frozen. IF/ID is flushed to a bubble.
  - **stall:** PC and all IF/ID fields hold.
  - **advance:** IF/ID <= {i_imem_rdata, PC, PC+4, valid = 1}. PC <= PC + 4, wrapping at 32'hFFFF_FFFC to 0.
- HALT:
  - PC frozen and IF/ID holds a bubble.
  - i_stall, i_redirect and i_halt are all ignored.
  - o_halted = 1.
  - Only i_rst leaves HALT.
- Reset asserted mid-stall or mid-redirect overrides everything. The cycle after reset deassertion fetches from RESET_ADDR.
- All PC arithmetic is 32-bit unsigned; carries are discarded.

## Timing
- o_imem_raddr is combinational from the PC register, with zero added logic.
- Fetch to decode latency: 1 cycle. The word at PC appears on o_if_id_inst in the cycle after the edge that captured it.
- Redirect penalty: the word in IF/ID during the redirect cycle is squashed. The target instruction is valid in IF/ID 2 edges after i_redirect is sampled.
- Stall has no penalty: outputs hold exactly for as many cycles as i_stall is high.
- o_halted rises on the edge that samples i_halt in RUN.

## Configuration
- Macro FETCH_MISALIGN_FAULT_EN.
- **Defined:**
  - A redirect whose target has i_redirect_pc[1:0] != 0 does not load the PC.
  - The FSM enters HALT with IF/ID flushed.
  - An extra output o_fetch_fault (1 bit, reset 0) sets and stays sticky until reset.
- **Undefined:**
  - The target is loaded with bits [1:0] forced to 0.
  - o_fetch_fault does not exist.

## Structure
- Package fetch_pkg holds:
  - localparam NOP_INST = 32'h0000_0013.
  - The state typedef (RUN, HALT).
  - The default reset address.
- Sub-module if_id_reg: the pipeline register with hold (stall) and flush (bubble) controls, holding inst, pc, pc4 and valid.
- fetch_stage keeps the PC, the FSM and the priority logic.

## Test plan
- **Reset then run:** i_rst for 2 cycles, memory returns 32'h00A00093 at 0 and 32'h00100113 at 4.
  - o_imem_raddr = 0, then 4, then 8.
  - IF/ID = {00A00093, pc 0, pc4 4, valid 1}, then {00100113, 4, 8, 1}.
- **Stall for 3 cycles while IF/ID holds pc 4:**
  - PC stays 8 and IF/ID stays pc 4 for exactly 3 cycles.
  - The cycle after release, IF/ID = pc 8.
- **Redirect to 32'h100 asserted together with i_stall:**
  - Next cycle: PC = 0x100 and valid = 0.
  - Following cycle: IF/ID pc = 0x100, valid = 1.
- **i_halt and i_redirect in the same cycle:** redirect taken, o_halted stays 0.
- **i_halt alone:**
  - o_halted = 1, valid = 0, and PC frozen for 10 cycles despite redirect/stall pulses.
  - i_rst returns to PC = RESET_ADDR.
- **PC at 32'hFFFF_FFFC advances:** next PC = 0, and o_if_id_pc4 = 0.
- **With FETCH_MISALIGN_FAULT_EN, redirect to 32'h102:**
  - o_fetch_fault = 1 and o_halted = 1.
  - PC keeps its old value.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

  // ADDI x0, x0, 0 -- the canonical RV32I NOP used for pipeline bubbles.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // PC value loaded on reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid flag.
// Priority inside the register: reset > flush > hold > load.
// flush replaces the instruction with a NOP bubble but keeps pc/pc4.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, pc_q, pc4_q;
  logic        valid_q;

  // Pipeline register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= NOP_INST;
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0004;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, RUN/HALT state machine and the
// redirect > halt > stall > advance priority logic feeding IF/ID.
// Optional macro FETCH_MISALIGN_FAULT_EN: a redirect to a target that is
// not 4-byte aligned halts fetch and raises a sticky o_fetch_fault instead
// of loading the target with its low bits cleared.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic [31:0] o_if_id_inst,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic        o_if_id_valid,
`ifdef FETCH_MISALIGN_FAULT_EN
  output logic        o_fetch_fault,
`endif
  output logic        o_halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         ifid_hold, ifid_flush;
  logic         fault_set;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control, in redirect > halt > stall > advance order.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    fault_set  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (i_redirect) begin
          // A same-cycle i_halt is from the wrong path and is dropped here.
          ifid_flush = 1'b1;
`ifdef FETCH_MISALIGN_FAULT_EN
          if (i_redirect_pc[1:0] != 2'b00) begin
            state_d   = StHalt;
            fault_set = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
`else
          pc_d = redirect_target;
`endif
        end else if (i_halt) begin
          state_d    = StHalt;
          ifid_flush = 1'b1;
        end else if (i_stall) begin
          ifid_hold = 1'b1;
        end else begin
          pc_d = pc_plus4;
        end
      end
      StHalt: begin
        // IF/ID already holds the bubble written on entry.
        ifid_hold = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    o_halted = (state_q == StHalt);
  end

  // Program counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_FAULT_EN
  logic fault_q;

  // Sticky misalignment fault, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_q | fault_set;
    end
  end

  assign o_fetch_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = fault_set;
`endif

  assign o_imem_raddr = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .hold_i  (ifid_hold),
    .flush_i (ifid_flush),
    .inst_i  (i_imem_rdata),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .inst_o  (o_if_id_inst),
    .pc_o    (o_if_id_pc),
    .pc4_o   (o_if_id_pc4),
    .valid_o (o_if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RA  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_MISALIGN_FAULT_EN
  logic        fetch_fault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
  logic        m_valid, m_halted, m_fault;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h00A0_0093;
    if (addr == 32'h4) return 32'h0010_0113;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_raddr);

  fetch_stage #(
    .RESET_ADDR (RA)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_raddr  (imem_raddr),
    .i_imem_rdata  (imem_rdata),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_if_id_inst  (if_id_inst),
    .o_if_id_pc    (if_id_pc),
    .o_if_id_pc4   (if_id_pc4),
    .o_if_id_valid (if_id_valid),
`ifdef FETCH_MISALIGN_FAULT_EN
    .o_fetch_fault (fetch_fault),
`endif
    .o_halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the fetch rules for one clock edge to the model.
  task automatic model_edge(input logic r, input logic s, input logic rd,
                            input logic [31:0] rpc, input logic h);
    logic misaligned;
`ifdef FETCH_MISALIGN_FAULT_EN
    misaligned = (rpc % 4) != 0;
`else
    misaligned = 1'b0;
`endif
    if (r) begin
      m_pc = RA; m_inst = NOP; m_ipc = 0; m_ipc4 = 4;
      m_valid = 0; m_halted = 0; m_fault = 0;
    end else if (m_halted) begin
      // frozen
    end else if (rd) begin
      m_inst = NOP; m_valid = 0;
      if (misaligned) begin
        m_halted = 1; m_fault = 1;
      end else begin
        m_pc = rpc - (rpc % 4);
      end
    end else if (h) begin
      m_halted = 1; m_inst = NOP; m_valid = 0;
    end else if (!s) begin
      m_inst = mem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_model();
    check_eq("raddr", imem_raddr, m_pc);
    check_eq("inst", if_id_inst, m_inst);
    check_eq("ifid_pc", if_id_pc, m_ipc);
    check_eq("ifid_pc4", if_id_pc4, m_ipc4);
    check_eq("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef FETCH_MISALIGN_FAULT_EN
    check_eq("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
  endtask

  // One clock: drive inputs, take the edge, update the model, then compare.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic h);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
    @(posedge clk);
    model_edge(r, s, rd, rpc, h);
    #1;
    compare_model();
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
    m_fault = 0;

    // Reset then run.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("rst_raddr", imem_raddr, 32'h0);
    check_eq("rst_inst", if_id_inst, NOP);
    check_eq("rst_pc4", if_id_pc4, 32'h4);
    check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    check_eq("run0_raddr", imem_raddr, 32'h4);
    check_eq("run0_inst", if_id_inst, 32'h00A0_0093);
    check_eq("run0_pc", if_id_pc, 32'h0);
    step(0, 0, 0, 0, 0);
    check_eq("run1_raddr", imem_raddr, 32'h8);
    check_eq("run1_inst", if_id_inst, 32'h0010_0113);
    check_eq("run1_pc4", if_id_pc4, 32'h8);

    // Stall three cycles while IF/ID holds pc 4.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      check_eq("stall_raddr", imem_raddr, 32'h8);
      check_eq("stall_pc", if_id_pc, 32'h4);
    end
    step(0, 0, 0, 0, 0);
    check_eq("unstall_pc", if_id_pc, 32'h8);

    // Redirect together with stall.
    step(0, 1, 1, 32'h100, 0);
    check_eq("redir_raddr", imem_raddr, 32'h100);
    check_eq("redir_valid", {31'b0, if_id_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    check_eq("redir_tgt_pc", if_id_pc, 32'h100);
    check_eq("redir_tgt_valid", {31'b0, if_id_valid}, 32'h1);

    // Halt and redirect in the same cycle: redirect wins.
    step(0, 0, 1, 32'h200, 1);
    check_eq("hr_halted", {31'b0, halted}, 32'h0);
    check_eq("hr_raddr", imem_raddr, 32'h200);

    // Halt alone, then ignore everything for 10 cycles.
    step(0, 0, 0, 0, 1);
    check_eq("halt_halted", {31'b0, halted}, 32'h1);
    check_eq("halt_valid", {31'b0, if_id_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], i[1], 32'h300, i[2]);
      check_eq("halt_frozen", imem_raddr, 32'h200);
    end
    step(1, 0, 0, 0, 0);
    check_eq("halt_rst_raddr", imem_raddr, RA);
    check_eq("halt_rst_halted", {31'b0, halted}, 32'h0);

    // PC wrap.
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    check_eq("wrap_raddr", imem_raddr, 32'h0);
    check_eq("wrap_pc4", if_id_pc4, 32'h0);

    // Misaligned redirect.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_FAULT_EN
    check_eq("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check_eq("mis_halted", {31'b0, halted}, 32'h1);
    check_eq("mis_raddr", imem_raddr, 32'h4);
`else
    check_eq("mis_raddr", imem_raddr, 32'h100);
    check_eq("mis_halted", {31'b0, halted}, 32'h0);
`endif

    // Randomized control traffic.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        r, s, rd, h;
      logic [31:0] rpc;
      r   = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      h   = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(r, s, rd, rpc, h);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
